// File: rtl/disp_scroll_ctrl.sv
// Scroll controller for the 4-digit seven-segment mux: circular buffer of raw
// segment patterns, a 4-entry registered window, run/pause stepping and wrap pulse.
module disp_scroll_ctrl #(
  parameter int W_ADDR = 4,
  parameter int DVSR   = 25000000,
  parameter int DVSR_W = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [W_ADDR-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [W_ADDR:0]   len,
  input  logic              run,
  input  logic              dir,
  input  logic              step,
  output logic [7:0]        in3,
  output logic [7:0]        in2,
  output logic [7:0]        in1,
  output logic [7:0]        in0,
  output logic [W_ADDR-1:0] pos,
  output logic              wrap
);

  localparam int              DEPTH   = 1 << W_ADDR;
  localparam logic [W_ADDR:0] DEPTH_L = (W_ADDR+1)'(DEPTH);
  localparam logic [DVSR_W-1:0] CNT_MAX = DVSR_W'(DVSR - 1);

  typedef enum logic {PAUSE, RUN} state_e;

  state_e              state_q;
  logic [DVSR_W-1:0]   cnt_q, cnt_d;
  logic [W_ADDR-1:0]   pos_q, pos_d;
  logic                wrap_q, wrap_d;
  logic [7:0]          buf_q [DEPTH];
  logic [7:0]          in3_q, in2_q, in1_q, in0_q;
  logic [7:0]          in3_d, in2_d, in1_d, in0_d;
  logic [W_ADDR:0]     len_l;
  logic                tick;
  logic [W_ADDR-1:0]   i2, i1, i0;

  function automatic logic [W_ADDR:0] sat_len(input logic [W_ADDR:0] l);
    return (l > DEPTH_L) ? DEPTH_L : l;
  endfunction

  function automatic logic [W_ADDR-1:0] nxt_idx(input logic [W_ADDR-1:0] i,
                                                input logic [W_ADDR:0]   l);
    logic [W_ADDR:0] ip1;
    ip1 = {1'b0, i} + (W_ADDR+1)'(1);
    return (ip1 >= l) ? '0 : ip1[W_ADDR-1:0];
  endfunction

  function automatic logic [W_ADDR-1:0] prv_idx(input logic [W_ADDR-1:0] i,
                                                input logic [W_ADDR:0]   l);
    logic [W_ADDR:0] lm1;
    lm1 = l - (W_ADDR+1)'(1);
    return (i == '0) ? lm1[W_ADDR-1:0] : i - W_ADDR'(1);
  endfunction

  always_comb begin
    len_l  = sat_len(len);
    tick   = (state_q == RUN) ? (cnt_q == CNT_MAX) : step;
    cnt_d  = (state_q == RUN && cnt_q != CNT_MAX) ? cnt_q + DVSR_W'(1) : '0;
    pos_d  = pos_q;
    wrap_d = 1'b0;
    // An out-of-range pos (length shrank) is pulled home before any advance.
    if (len_l == '0 || {1'b0, pos_q} >= len_l) begin
      pos_d = '0;
    end else if (tick) begin
      if (!dir) begin
        pos_d  = nxt_idx(pos_q, len_l);
        wrap_d = (pos_d == '0);
      end else begin
        pos_d  = prv_idx(pos_q, len_l);
        wrap_d = (pos_q == '0);
      end
    end
  end

  // Window stage: registered from buffer and pos as they stand before the edge
  always_comb begin
    i2 = nxt_idx(pos_q, len_l);
    i1 = nxt_idx(i2, len_l);
    i0 = nxt_idx(i1, len_l);
    if (len_l == '0) begin
      in3_d = 8'hFF;
      in2_d = 8'hFF;
      in1_d = 8'hFF;
      in0_d = 8'hFF;
    end else begin
      in3_d = buf_q[pos_q];
      in2_d = buf_q[i2];
      in1_d = buf_q[i1];
      in0_d = buf_q[i0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PAUSE;
      cnt_q   <= '0;
      pos_q   <= '0;
      wrap_q  <= 1'b0;
      buf_q   <= '{default: 8'hFF};
      in3_q   <= 8'hFF;
      in2_q   <= 8'hFF;
      in1_q   <= 8'hFF;
      in0_q   <= 8'hFF;
    end else begin
      case (state_q)
        PAUSE:   if (run)  state_q <= RUN;
        RUN:     if (!run) state_q <= PAUSE;
        default: state_q <= PAUSE;
      endcase
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      wrap_q <= wrap_d;
      if (wr_en) buf_q[wr_addr] <= wr_data;
      in3_q  <= in3_d;
      in2_q  <= in2_d;
      in1_q  <= in1_d;
      in0_q  <= in0_d;
    end
  end

  assign in3  = in3_q;
  assign in2  = in2_q;
  assign in1  = in1_q;
  assign in0  = in0_q;
  assign pos  = pos_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_disp_scroll_ctrl.sv
// Directed vector bench for disp_scroll_ctrl (W_ADDR=4, DVSR=4).
module tb_disp_scroll_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [4:0] len = '0;
  logic       run = 1'b0;
  logic       dir = 1'b0;
  logic       step = 1'b0;
  logic [7:0] in3, in2, in1, in0;
  logic [3:0] pos;
  logic       wrap;

  int passed = 0;
  int total  = 0;

  disp_scroll_ctrl #(.W_ADDR(4), .DVSR(4), .DVSR_W(3)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .run(run), .dir(dir), .step(step),
    .in3(in3), .in2(in2), .in1(in1), .in0(in0), .pos(pos), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [7:0]  wd;
    logic [4:0]  ln;
    logic        r, d, s;
    int          n;
    logic        cw;
    logic [31:0] ew;
    logic [3:0]  ep;
    logic        ewr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                              input logic [4:0] ln, input logic r, input logic d,
                              input logic s, input int n, input logic cw,
                              input logic [31:0] ew, input logic [3:0] ep, input logic ewr);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ln = ln; v.r = r; v.d = d; v.s = s;
    v.n = n; v.cw = cw; v.ew = ew; v.ep = ep; v.ewr = ewr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // write phase, paused
    tbl.push_back(mk(1, 0, 8'h01, 6, 0, 0, 0, 1, 1, 32'hFFFFFFFF, 0, 0));
    tbl.push_back(mk(1, 1, 8'h02, 6, 0, 0, 0, 1, 1, 32'h01FFFFFF, 0, 0));
    tbl.push_back(mk(1, 2, 8'h03, 6, 0, 0, 0, 1, 1, 32'h0102FFFF, 0, 0));
    tbl.push_back(mk(1, 3, 8'h04, 6, 0, 0, 0, 1, 1, 32'h010203FF, 0, 0));
    tbl.push_back(mk(1, 4, 8'h05, 6, 0, 0, 0, 1, 1, 32'h01020304, 0, 0));
    tbl.push_back(mk(1, 5, 8'h06, 6, 0, 0, 0, 1, 1, 32'h01020304, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 6, 0, 0, 0, 1, 1, 32'h01020304, 0, 0));
    // auto-scroll left, one advance every 4 cycles
    tbl.push_back(mk(0, 0, 8'h00, 6, 1, 0, 0, 4, 1, 32'h01020304, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 6, 1, 0, 0, 1, 1, 32'h01020304, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 6, 1, 0, 0, 1, 1, 32'h02030405, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 6, 1, 0, 0, 3, 1, 32'h02030405, 2, 0));
    tbl.push_back(mk(0, 0, 8'h00, 6, 1, 0, 0, 4, 1, 32'h03040506, 3, 0));
    tbl.push_back(mk(0, 0, 8'h00, 6, 1, 0, 0, 4, 1, 32'h04050601, 4, 0));
    tbl.push_back(mk(0, 0, 8'h00, 6, 1, 0, 0, 4, 1, 32'h05060102, 5, 0));
    tbl.push_back(mk(0, 0, 8'h00, 6, 1, 0, 0, 3, 1, 32'h06010203, 5, 0));
    tbl.push_back(mk(0, 0, 8'h00, 6, 1, 0, 0, 1, 1, 32'h06010203, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 6, 1, 0, 0, 1, 1, 32'h01020304, 0, 0));
    // pause, single step right across the wrap, step ignored in run
    tbl.push_back(mk(0, 0, 8'h00, 6, 0, 1, 0, 1, 1, 32'h01020304, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 6, 0, 1, 1, 1, 1, 32'h01020304, 5, 1));
    tbl.push_back(mk(0, 0, 8'h00, 6, 0, 1, 0, 1, 1, 32'h06010203, 5, 0));
    tbl.push_back(mk(0, 0, 8'h00, 6, 1, 1, 0, 1, 1, 32'h06010203, 5, 0));
    tbl.push_back(mk(0, 0, 8'h00, 6, 1, 1, 1, 2, 1, 32'h06010203, 5, 0));
    tbl.push_back(mk(0, 0, 8'h00, 6, 0, 1, 0, 1, 1, 32'h06010203, 5, 0));
    // short messages, length changes, length 0 and saturation
    tbl.push_back(mk(1, 0, 8'hAA, 2, 0, 1, 0, 1, 0, 32'h0, 0, 0));
    tbl.push_back(mk(1, 1, 8'hBB, 2, 0, 1, 0, 1, 1, 32'hAA02AA02, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 2, 0, 1, 0, 1, 1, 32'hAABBAABB, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 2, 0, 0, 1, 1, 1, 32'hAABBAABB, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8, 0, 0, 0, 1, 1, 32'hBB030405, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 1, 32'hAAAAAAAA, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 1, 1, 32'hAAAAAAAA, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 1, 32'hAAAAAAAA, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 1, 1, 32'hFFFFFFFF, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFF, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 20, 0, 0, 0, 1, 1, 32'hAABB0304, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 20, 0, 1, 1, 1, 1, 32'hAABB0304, 15, 1));
    tbl.push_back(mk(0, 0, 8'h00, 20, 0, 1, 0, 1, 1, 32'hFFAABB03, 15, 0));
    // write and advance in the same cycle
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 0, 1, 0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 0, 1, 1, 32'hAABB0304, 0, 0));
    tbl.push_back(mk(1, 0, 8'h7E, 4, 0, 0, 1, 1, 1, 32'hAABB0304, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 0, 1, 1, 32'hBB03047E, 1, 0));

    // asynchronous reset, then release between edges
    #2 reset = 1'b1;
    #1;
    chk("rst_win", {in3, in2, in1, in0}, 32'hFFFFFFFF);
    chk("rst_pos", {28'h0, pos}, 32'h0);
    chk("rst_wrap", {31'h0, wrap}, 32'h0);
    edges(2);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      len = tbl[i].ln; run = tbl[i].r; dir = tbl[i].d; step = tbl[i].s;
      edges(tbl[i].n);
      chk($sformatf("v%0d_pos", i), {28'h0, pos}, {28'h0, tbl[i].ep});
      chk($sformatf("v%0d_wrap", i), {31'h0, wrap}, {31'h0, tbl[i].ewr});
      if (tbl[i].cw) chk($sformatf("v%0d_win", i), {in3, in2, in1, in0}, tbl[i].ew);
    end

    // reset mid-run, then confirm the state stays paused until run is seen
    wr_en = 1'b0; step = 1'b0; len = 5'd4; dir = 1'b0; run = 1'b1;
    edges(5);
    chk("mid_pos_before", {28'h0, pos}, 32'h2);
    #3 reset = 1'b1;
    run = 1'b0;
    #1;
    chk("mid_rst_win", {in3, in2, in1, in0}, 32'hFFFFFFFF);
    chk("mid_rst_pos", {28'h0, pos}, 32'h0);
    chk("mid_rst_wrap", {31'h0, wrap}, 32'h0);
    edges(1);
    reset = 1'b0;
    edges(6);
    chk("post_pause_pos", {28'h0, pos}, 32'h0);
    chk("post_buf_lost", {in3, in2, in1, in0}, 32'hFFFFFFFF);
    run = 1'b1;
    edges(4);
    chk("post_run_no_tick", {28'h0, pos}, 32'h0);
    edges(1);
    chk("post_run_tick", {28'h0, pos}, 32'h1);
    chk("post_run_wrap", {31'h0, wrap}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
